syngen_sched: RTL and testbench
===============================

# syngen_sched

Sequencing controller for the constant-weight syndrome generator (`syngen`) in the signature path. It accepts a 178-bit message hash from the host, starts `syngen`, and watches its 2-bit status stream. It collects the error-vector indices of the current attempt into a local buffer and discards them whenever `syngen` restarts an attempt. On success it drains the final index set to the downstream signer over a valid/ready port; on attempt exhaustion, overflow or hang it aborts `syngen` and reports failure.

## Interface
- `DEPTH`, 16: index buffer entries; maximum error-vector weight accepted.
- `MAX_TRY`, 64: maximum attempts, i.e. status `10` events per request.
- `TIMEOUT`, 1024: watchdog limit, in cycles without a `01`/`10`/`11` status.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  host request.
- `req_ready`  out  1  high only in IDLE.
- `req_hash`  in  178  message hash; captured on `req_valid && req_ready`.
- `syn_start`  out  1  start pulse to `syngen`.
- `syn_hash`  out  178  captured hash, held stable until the next capture.
- `syn_rst_b`  out  1  active-low reset to `syngen`.
- `syn_err_valid`  in  2  `syngen` status: `00` idle/invalid, `01` index valid, `10` clear vector (new attempt), `11` all found/idle.
- `syn_err_idx`  in  13  index, qualified by `01`.
- `idx_valid`  out  1  output index beat.
- `idx_ready`  in  1  downstream accept.
- `idx_data`  out  13  buffered index.
- `idx_last`  out  1  marks the final beat of a vector.
- `done`  out  1  one-cycle success pulse.
- `fail`  out  1  one-cycle failure pulse.
- `fail_code`  out  2  failure reason, valid with `fail`: 1 = tries exhausted, 2 = overflow, 3 = timeout.
- `tries`  out  7  attempts used by the last request.

## Operation
- **States:** IDLE, START, ARM, COLLECT, DRAIN, ABORT.
- **IDLE.**
  - `req_ready`=1.
  - On handshake: latch the hash, clear the buffer, `tries`, the overflow flag and the watchdog; go to START.
- **START.**
  - `syn_start`=1 for exactly one cycle; go to ARM.
- **ARM.**
  - Ignore `11` and `00`.
  - First `10`: `tries`=1, clear the buffer; go to COLLECT.
- **COLLECT**, per status:
  - `01`: write `syn_err_idx` at the write pointer and increment the count.
    - If the count already equals `DEPTH`, drop the write and set the sticky overflow flag.
  - `10`: clear the count and the overflow flag; `tries`++.
    - If `tries` would exceed `MAX_TRY`, go to ABORT with code 1.
  - `11`: attempt passed.
    - Overflow set: go to ABORT with code 2.
    - Otherwise go to DRAIN.
  - `00`: no action.
- **DRAIN.**
  - Present entries in write order; advance on `idx_valid && idx_ready`.
  - `idx_last` is asserted with entry count−1.
  - After the last accepted beat: `done` pulse, go to IDLE.
  - Count 0: `done` pulses on DRAIN entry with no beats.
- **ABORT.**
  - Drive `syn_rst_b`=0 for 4 cycles.
  - Then `fail` pulse with `fail_code`; go to IDLE.
- **Watchdog.**
  - Active in ARM and COLLECT; counts cycles and resets on any `01`, `10` or `11` seen in COLLECT (`10` in ARM).
  - Reaching `TIMEOUT` forces ABORT with code 3.
  - Tries-exhausted has priority over timeout in the same cycle.
- Status is ignored outside ARM and COLLECT.
- `tries` holds its value after completion until the next request is accepted.

## Timing
- **Reset values:** state IDLE; `req_ready`=1; `syn_start`=0; `syn_rst_b`=0 during `rst`, 1 after; `idx_valid`=0; `idx_last`=0; `done`=0; `fail`=0; `fail_code`=0; `tries`=0; `syn_hash`=0.
- **Request to start:** `req_ready` drops the cycle after the handshake. `syn_start` is high in that same cycle, one cycle after the capture edge.
- **Status sampling:** `syn_err_valid` and `syn_err_idx` are sampled registered on each edge; the buffer write completes 1 cycle after `01`.
- **Success:** `11` to first `idx_valid` is 1 cycle. `idx_data` and `idx_last` stay stable while `idx_valid` is high and `idx_ready` is low. `done` is high the cycle after the last accept.
- **Back-to-back:** a new request may be accepted the cycle after `done` or `fail`.
- **Reset mid-operation:** `rst` in any state returns to IDLE next cycle, drops `idx_valid`, and emits no `done`/`fail`.

## Test plan
- **Normal pass:** request hash H; model emits `10`, three `01` (idx 5, 4899, 12), then `11`. Required: beats 5, 4899, 12 with `idx_last` on 12; `done`; `tries`=1.
- **Retry:** `10`, `01`(7), `10`, `01`(9), `01`(3), `11`. Required: only 9 and 3 output; `tries`=2.
- **Backpressure:** hold `idx_ready`=0 for 5 cycles mid-drain. Required: `idx_data` stable, no beat lost or duplicated.
- **Exhaustion:** 65 `10` events with no `11`. Required: 4 cycles of `syn_rst_b`=0, then `fail` with `fail_code`=1.
- **Overflow:** 17 `01` within one attempt, then `11`. Required: `fail` with `fail_code`=2. A following `10` before the `11` instead clears overflow and the attempt proceeds normally.
- **Timeout and reset:**
  - Status stuck at `00` for 1024 cycles in COLLECT: `fail_code`=3.
  - `rst` asserted mid-DRAIN: `idx_valid`=0 next cycle, `req_ready`=1, no `done`.

Source files
------------

// File: rtl/syngen_sched.sv
// syngen_sched: sequences syngen, buffers the winning attempt's error indices and
// drains them downstream; aborts syngen on exhaustion, overflow or watchdog expiry.
module syngen_sched #(
    parameter int DEPTH   = 16,
    parameter int MAX_TRY = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [177:0] req_hash,
    output logic         syn_start,
    output logic [177:0] syn_hash,
    output logic         syn_rst_b,
    input  logic [1:0]   syn_err_valid,
    input  logic [12:0]  syn_err_idx,
    output logic         idx_valid,
    input  logic         idx_ready,
    output logic [12:0]  idx_data,
    output logic         idx_last,
    output logic         done,
    output logic         fail,
    output logic [1:0]   fail_code,
    output logic [6:0]   tries
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, START, ARM, COLLECT, DRAIN, ABORT} state_t;
    state_t        state;
    logic [12:0]   mem [DEPTH];
    logic [CW-1:0] cnt;
    logic [PW-1:0] rd;
    logic [WW-1:0] wd;
    logic [1:0]    ac;
    logic [1:0]    code;
    logic          ovf;
    logic          wr_en;
    logic          wd_exp;
    logic          last_beat;
    assign req_ready = state == IDLE;
    assign syn_start = state == START;
    assign syn_rst_b = !rst && state != ABORT;
    assign idx_valid = state == DRAIN && cnt != '0;
    assign idx_data  = mem[rd];
    assign last_beat = CW'(rd) + CW'(1) == cnt;
    assign idx_last  = idx_valid && last_beat;
    assign wr_en     = state == COLLECT && syn_err_valid == 2'b01 && cnt != CW'(DEPTH);
    assign wd_exp    = wd == WW'(TIMEOUT - 1);
    always_ff @(posedge clk)
        if (wr_en) mem[cnt[PW-1:0]] <= syn_err_idx;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            syn_hash  <= '0;
            cnt       <= '0;
            rd        <= '0;
            wd        <= '0;
            ac        <= '0;
            code      <= '0;
            ovf       <= 1'b0;
            tries     <= '0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= '0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    syn_hash <= req_hash;
                    cnt      <= '0;
                    tries    <= '0;
                    ovf      <= 1'b0;
                    wd       <= '0;
                    state    <= START;
                end
                START: state <= ARM;
                ARM: if (syn_err_valid == 2'b10) begin
                    tries <= 7'd1;
                    cnt   <= '0;
                    wd    <= '0;
                    state <= COLLECT;
                end else if (wd_exp) begin
                    code  <= 2'd3;
                    state <= ABORT;
                end else wd <= wd + 1'b1;
                COLLECT: case (syn_err_valid)
                    2'b01: begin
                        wd <= '0;
                        if (cnt == CW'(DEPTH)) ovf <= 1'b1;
                        else cnt <= cnt + 1'b1;
                    end
                    2'b10: begin
                        wd  <= '0;
                        cnt <= '0;
                        ovf <= 1'b0;
                        if (tries == 7'(MAX_TRY)) begin
                            code  <= 2'd1;
                            state <= ABORT;
                        end else tries <= tries + 1'b1;
                    end
                    2'b11: begin
                        wd    <= '0;
                        rd    <= '0;
                        code  <= 2'd2;
                        state <= ovf ? ABORT : DRAIN;
                    end
                    default: if (wd_exp) begin
                        code  <= 2'd3;
                        state <= ABORT;
                    end else wd <= wd + 1'b1;
                endcase
                DRAIN: if (cnt == '0 || (idx_ready && last_beat)) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end else if (idx_ready) rd <= rd + 1'b1;
                // syn_rst_b is low for exactly the four cycles spent here
                ABORT: if (ac == 2'd3) begin
                    ac        <= '0;
                    fail      <= 1'b1;
                    fail_code <= code;
                    state     <= IDLE;
                end else ac <= ac + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_syngen_sched.sv
// tb_syngen_sched: directed stimulus with a queue-based scoreboard for syngen_sched.
module tb_syngen_sched;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [177:0] req_hash = '0;
    logic         syn_start;
    logic [177:0] syn_hash;
    logic         syn_rst_b;
    logic [1:0]   syn_err_valid = 2'b00;
    logic [12:0]  syn_err_idx = '0;
    logic         idx_valid;
    logic         idx_ready = 1'b1;
    logic [12:0]  idx_data;
    logic         idx_last;
    logic         done;
    logic         fail;
    logic [1:0]   fail_code;
    logic [6:0]   tries;
    int           total = 0;
    int           bad = 0;
    logic [22:0]  q[$];
    int           lowc = 0;
    logic         hold_v = 1'b0;
    logic [13:0]  hold_d = '0;

    syngen_sched dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_hash(req_hash), .syn_start(syn_start), .syn_hash(syn_hash),
        .syn_rst_b(syn_rst_b), .syn_err_valid(syn_err_valid), .syn_err_idx(syn_err_idx),
        .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_data(idx_data),
        .idx_last(idx_last), .done(done), .fail(fail), .fail_code(fail_code), .tries(tries)
    );

    always #5 clk = ~clk;

    function automatic logic [22:0] fb(input logic [12:0] d, input logic l);
        return {2'd0, d, l, 7'd0};
    endfunction
    function automatic logic [22:0] fd(input logic [6:0] t);
        return {2'd1, 14'd0, t};
    endfunction
    function automatic logic [22:0] ff(input logic [1:0] c, input logic [6:0] t);
        return {2'd2, 11'd0, c, 1'b0, t};
    endfunction
    function automatic logic [177:0] mkh(input int s);
        return {18'(s), 32'(s * 7), 32'(~s), 32'(s ^ 32'h5a5a5a5a), 32'(s + 1), 32'(s * 13)};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [22:0] act);
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected output %0h, nothing expected", name, act);
        end else chk(name, 256'(act), 256'(q.pop_front()));
    endtask

    // monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) if (!rst) begin
        if (!syn_rst_b) lowc++;
        if (idx_valid && hold_v) chk("stable", 256'({idx_data, idx_last}), 256'(hold_d));
        hold_v = idx_valid && !idx_ready;
        hold_d = {idx_data, idx_last};
        if (idx_valid && idx_ready) pop_chk("beat", fb(idx_data, idx_last));
        if (done) pop_chk("done", fd(tries));
        if (fail) begin
            pop_chk("fail", ff(fail_code, tries));
            chk("rst_b_low_cycles", 256'(lowc), 256'(4));
            lowc = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [1:0] v, input logic [12:0] i);
        syn_err_valid = v;
        syn_err_idx = i;
        tick();
        syn_err_valid = 2'b00;
    endtask

    task automatic request(input int s);
        req_valid = 1'b1;
        req_hash = mkh(s);
        tick();
        req_valid = 1'b0;
        chk("syn_start", 256'(syn_start), 256'(1));
        chk("req_ready_low", 256'(req_ready), 256'(0));
        chk("syn_hash", 256'(syn_hash), 256'(mkh(s)));
        tick();
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 3000 && q.size() != 0; i++) tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: timed out with %0d expected outputs pending", name, q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        chk("rst_syn_start", 256'(syn_start), 256'(0));
        chk("rst_syn_rst_b", 256'(syn_rst_b), 256'(0));
        chk("rst_idx_valid", 256'({idx_valid, idx_last}), 256'(0));
        chk("rst_done_fail", 256'({done, fail, fail_code}), 256'(0));
        chk("rst_tries", 256'(tries), 256'(0));
        chk("rst_syn_hash", 256'(syn_hash), 256'(0));
        rst = 1'b0;
        tick();
        chk("syn_rst_b_after", 256'(syn_rst_b), 256'(1));

        // normal pass, with 11 in ARM ignored
        q.push_back(fb(5, 0)); q.push_back(fb(4899, 0)); q.push_back(fb(12, 1)); q.push_back(fd(1));
        request(1);
        st(2'b11, 0); st(2'b00, 0);
        st(2'b10, 0); st(2'b01, 5); st(2'b01, 4899); st(2'b01, 12); st(2'b11, 0);
        wait_empty("normal");
        chk("tries_hold", 256'(tries), 256'(1));

        // retry discards the first attempt
        q.push_back(fb(9, 0)); q.push_back(fb(3, 1)); q.push_back(fd(2));
        request(2);
        st(2'b10, 0); st(2'b01, 7); st(2'b10, 0); st(2'b01, 9); st(2'b01, 3); st(2'b11, 0);
        wait_empty("retry");

        // backpressure mid-drain
        q.push_back(fb(100, 0)); q.push_back(fb(200, 0)); q.push_back(fb(300, 0));
        q.push_back(fb(400, 1)); q.push_back(fd(1));
        request(3);
        st(2'b10, 0); st(2'b01, 100); st(2'b01, 200); st(2'b01, 300); st(2'b01, 400);
        st(2'b11, 0); tick();
        idx_ready = 1'b0;
        repeat (5) tick();
        idx_ready = 1'b1;
        wait_empty("backpressure");

        // tries exhausted after 65 clear events
        q.push_back(ff(1, 64));
        request(4);
        repeat (65) st(2'b10, 0);
        wait_empty("exhaust");

        // overflow: 17 indices then pass
        q.push_back(ff(2, 1));
        request(5);
        st(2'b10, 0);
        for (int i = 0; i < 17; i++) st(2'b01, 13'(i + 1));
        st(2'b11, 0);
        wait_empty("overflow");

        // overflow cleared by a new attempt, then a full buffer drains
        for (int i = 0; i < 16; i++) q.push_back(fb(13'(1000 + i), i == 15));
        q.push_back(fd(2));
        request(6);
        st(2'b10, 0);
        for (int i = 0; i < 17; i++) st(2'b01, 13'(i + 50));
        st(2'b10, 0);
        for (int i = 0; i < 16; i++) st(2'b01, 13'(1000 + i));
        st(2'b11, 0);
        wait_empty("overflow_clear");

        // watchdog expiry in COLLECT
        q.push_back(ff(3, 1));
        request(7);
        st(2'b10, 0);
        wait_empty("timeout");

        // empty vector: done with no beats
        q.push_back(fd(1));
        request(8);
        st(2'b10, 0); st(2'b11, 0);
        wait_empty("empty");

        // reset mid-drain: no beats accepted, no done
        idx_ready = 1'b0;
        request(9);
        st(2'b10, 0); st(2'b01, 1); st(2'b01, 2); st(2'b11, 0);
        chk("drain_valid", 256'({idx_valid, idx_data}), 256'({1'b1, 13'd1}));
        rst = 1'b1;
        tick();
        chk("rst_drop_valid", 256'(idx_valid), 256'(0));
        chk("rst_req_ready", 256'(req_ready), 256'(1));
        rst = 1'b0;
        idx_ready = 1'b1;
        repeat (5) tick();
        chk("rst_no_output", 256'({done, fail}), 256'(0));
        chk("rst_tries_clear", 256'(tries), 256'(0));

        // back-to-back request right after done
        q.push_back(fb(77, 1)); q.push_back(fd(1));
        request(10);
        st(2'b10, 0); st(2'b01, 77); st(2'b11, 0);
        wait_empty("b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
